// File: rtl/gp_cmd_scheduler.sv
// Queues CPU stores of GP frame/code and issues them to the graphics processor one at a
// time over a valid/done handshake, optionally requesting a pixel-feeder flip on completion.
module gp_cmd_scheduler #(
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 CmdWrite,
  input  logic [31:0]          CmdFrame,
  input  logic [31:0]          CmdCode,
  input  logic                 CmdFlip,
  input  logic                 Flush,
  output logic                 CmdReady,
  output logic [LOG_DEPTH:0]   Count,
  output logic                 Busy,
  output logic [7:0]           DropCount,
  output logic [31:0]          gpFrame,
  output logic [31:0]          gpCode,
  output logic                 gpValid,
  input  logic                 gpDone,
  output logic                 FlipReq
);

  typedef struct packed {
    logic        flip;
    logic [31:0] frame;
    logic [31:0] code;
  } cmdEntry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [LOG_DEPTH-1:0] PTR_ONE   = LOG_DEPTH'(1);
  localparam logic [LOG_DEPTH:0]   COUNT_ONE = (LOG_DEPTH + 1)'(1);
  localparam logic [LOG_DEPTH:0]   COUNT_MAX = (LOG_DEPTH + 1)'(DEPTH);

  cmdEntry_t            mem [DEPTH];
  cmdEntry_t            head;
  logic [LOG_DEPTH-1:0] rdPtr;
  logic [LOG_DEPTH-1:0] wrPtr;
  state_t               state;
  state_t               stateNext;
  logic                 flipPending;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;

  assign full     = (Count == COUNT_MAX);
  assign CmdReady = !full;
  assign head     = mem[rdPtr];

  // A pop frees a slot on the same edge, so a push into a full FIFO still fits then.
  assign push = CmdWrite && !Flush && (!full || pop);
  assign drop = CmdWrite && !Flush && full && !pop;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (Count != '0) begin
          pop       = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE:   stateNext = WAIT;
      WAIT:    if (gpDone) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: the storage array has no reset; Count and the pointers alone decide validity.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wrPtr] <= '{flip: CmdFlip, frame: CmdFrame, code: CmdCode};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      Count     <= '0;
      DropCount <= '0;
    end else begin
      if (Flush) begin
        rdPtr <= wrPtr;
        Count <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + PTR_ONE;
        if (pop)  rdPtr <= rdPtr + PTR_ONE;
        if (push && !pop)      Count <= Count + COUNT_ONE;
        else if (pop && !push) Count <= Count - COUNT_ONE;
      end
      if (drop && (DropCount != 8'hFF)) begin
        DropCount <= DropCount + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      gpFrame     <= '0;
      gpCode      <= '0;
      gpValid     <= 1'b0;
      FlipReq     <= 1'b0;
      flipPending <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      state   <= stateNext;
      gpValid <= pop;
      Busy    <= (stateNext != IDLE);
      FlipReq <= (state == WAIT) && gpDone && flipPending;
      if (pop) begin
        gpFrame     <= head.frame;
        gpCode      <= head.code;
        flipPending <= head.flip;
      end
    end
  end

endmodule

// File: tb/tb_gp_cmd_scheduler.sv
// Bench for gp_cmd_scheduler: directed scenarios plus random traffic, compared every cycle
// against a transaction-level queue model of the scheduler.
module tb_gp_cmd_scheduler;

  localparam int DEPTH     = 4;
  localparam int LOG_DEPTH = 2;

  logic                Clk = 1'b0;
  logic                Reset;
  logic                CmdWrite;
  logic [31:0]         CmdFrame;
  logic [31:0]         CmdCode;
  logic                CmdFlip;
  logic                Flush;
  logic                CmdReady;
  logic [LOG_DEPTH:0]  Count;
  logic                Busy;
  logic [7:0]          DropCount;
  logic [31:0]         gpFrame;
  logic [31:0]         gpCode;
  logic                gpValid;
  logic                gpDone;
  logic                FlipReq;

  gp_cmd_scheduler #(.DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .CmdWrite(CmdWrite), .CmdFrame(CmdFrame), .CmdCode(CmdCode),
    .CmdFlip(CmdFlip), .Flush(Flush), .CmdReady(CmdReady), .Count(Count), .Busy(Busy),
    .DropCount(DropCount), .gpFrame(gpFrame), .gpCode(gpCode), .gpValid(gpValid),
    .gpDone(gpDone), .FlipReq(FlipReq)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a queue of pending commands plus the in-flight command and the edge it popped on.
  logic [64:0] mq[$];
  bit          mInflight;
  int          mPopEdge;
  bit          mCurFlip;
  logic [31:0] mFrame, mCode;
  int          mDrops;
  bit          mValid, mFlip;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit wr, input logic [31:0] fr, input logic [31:0] cd, input bit fl,
                      input bit fls, input bit done, input bit rst);
    bit popNow;
    logic [64:0] e;
    CmdWrite = wr; CmdFrame = fr; CmdCode = cd; CmdFlip = fl;
    Flush = fls; gpDone = done; Reset = rst;
    @(posedge Clk);
    cyc++;
    mValid = 0;
    mFlip  = 0;
    if (rst) begin
      mq.delete();
      mInflight = 0; mCurFlip = 0; mFrame = '0; mCode = '0; mDrops = 0;
    end else begin
      popNow = !mInflight && (mq.size() > 0);
      // Done only counts once the issue cycle has passed.
      if (mInflight && done && (cyc > mPopEdge + 1)) begin
        mFlip     = mCurFlip;
        mInflight = 0;
      end
      if (popNow) begin
        e = mq.pop_front();
        {mCurFlip, mFrame, mCode} = e;
        mInflight = 1;
        mPopEdge  = cyc;
        mValid    = 1;
      end
      if (fls) mq.delete();
      else if (wr) begin
        if (mq.size() < DEPTH) mq.push_back({fl, fr, cd});
        else if (mDrops < 255) mDrops++;
      end
    end
    #1;
    check("gpValid",   64'(gpValid),   64'(mValid));
    check("FlipReq",   64'(FlipReq),   64'(mFlip));
    check("Busy",      64'(Busy),      64'(mInflight));
    check("Count",     64'(Count),     64'(mq.size()));
    check("CmdReady",  64'(CmdReady),  64'(mq.size() < DEPTH));
    check("DropCount", 64'(DropCount), 64'(mDrops));
    check("gpFrame",   64'(gpFrame),   64'(mFrame));
    check("gpCode",    64'(gpCode),    64'(mCode));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [31:0] fr, input logic [31:0] cd, input bit fl);
    step(1, fr, cd, fl, 0, 0, 0);
  endtask

  task automatic done1();
    step(0, '0, '0, 0, 0, 1, 0);
  endtask

  task automatic doReset();
    step(0, '0, '0, 0, 0, 0, 1);
    step(0, '0, '0, 0, 0, 0, 1);
  endtask

  initial begin
    CmdWrite = 0; CmdFrame = '0; CmdCode = '0; CmdFlip = 0; Flush = 0; gpDone = 0; Reset = 1;
    doReset();
    check("rst_count", 64'(Count), 64'd0);
    check("rst_ready", 64'(CmdReady), 64'd1);

    // Single command with flip.
    push(32'h1040_0000, 32'h1, 1);
    check("t1_valid_early", 64'(gpValid), 64'd0);
    idle(1);
    check("t1_valid", 64'(gpValid), 64'd1);
    check("t1_frame", 64'(gpFrame), 64'h1040_0000);
    check("t1_code",  64'(gpCode),  64'h1);
    idle(4);
    done1();
    check("t1_flip",  64'(FlipReq), 64'd1);
    check("t1_busy",  64'(Busy),    64'd0);
    idle(1);
    check("t1_flip_once", 64'(FlipReq), 64'd0);
    check("t1_hold_code", 64'(gpCode), 64'h1);

    // Fill and overflow: six back-to-back pushes, gpDone held low.
    for (int i = 1; i <= 6; i++) push(32'h2000_0000 + i, i, 0);
    check("t2_count", 64'(Count), 64'd4);
    check("t2_ready", 64'(CmdReady), 64'd0);
    check("t2_drop",  64'(DropCount), 64'd1);
    for (int i = 2; i <= 5; i++) begin
      done1();
      idle(1);
      check("t2_order_valid", 64'(gpValid), 64'd1);
      check("t2_order_code",  64'(gpCode),  64'(i));
      idle(2);
    end
    done1();
    idle(2);

    // Push exactly on the pop edge with the FIFO full.
    for (int i = 0; i < 5; i++) push(32'h3000_0000, 32'h30 + i, 0);
    check("t3_full", 64'(Count), 64'd4);
    done1();
    push(32'h3000_0000, 32'h3F, 0);
    check("t3_count", 64'(Count), 64'd4);
    check("t3_valid", 64'(gpValid), 64'd1);
    check("t3_drop",  64'(DropCount), 64'd1);
    doReset();

    // Flush during WAIT with a push in the same cycle.
    push(32'h4000_0000, 32'h40, 1);
    for (int i = 1; i < 4; i++) push(32'h4000_0000, 32'h40 + i, 0);
    check("t4_count_pre", 64'(Count), 64'd3);
    step(1, 32'h4444_4444, 32'h44, 1, 1, 0, 0);
    check("t4_count", 64'(Count), 64'd0);
    check("t4_drop",  64'(DropCount), 64'd0);
    done1();
    check("t4_flip", 64'(FlipReq), 64'd1);
    idle(6);
    check("t4_code_held", 64'(gpCode), 64'h40);

    // Spurious done in IDLE, then reset while in WAIT with two queued.
    done1();
    check("t5_no_flip", 64'(FlipReq), 64'd0);
    for (int i = 0; i < 3; i++) push(32'h5000_0000, 32'h50 + i, 1);
    idle(2);
    doReset();
    check("t5_rst_frame", 64'(gpFrame), 64'd0);
    check("t5_rst_busy",  64'(Busy), 64'd0);
    done1();
    check("t5_rst_flip",  64'(FlipReq), 64'd0);
    check("t5_rst_count", 64'(Count), 64'd0);

    // Pointer wrap over ten push/complete rounds.
    for (int i = 0; i < 10; i++) begin
      push(32'h6000_0000 + i, 32'h600 + i, i[0]);
      idle(1);
      check("t6_code", 64'(gpCode), 64'(32'h600 + i));
      idle(2);
      done1();
      idle(1);
    end
    check("t6_count", 64'(Count), 64'd0);
    check("t6_drop",  64'(DropCount), 64'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1),
           $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gp_cmd_scheduler.md
# gp_cmd_scheduler

Command scheduler between the CPU's memory-mapped graphics-processor registers and the graphics processor (GP). CPU stores of frame address and command code are queued in a small FIFO. Queued commands are issued to the GP one at a time with a valid/done handshake. Each command can optionally request a pixel-feeder frame flip when the GP finishes it. The block sits beside the memory/write-back stage and replaces direct CPU writes to the GP frame/code registers.

## Interface
Parameters:
- DEPTH, 4, command FIFO depth; power of two, 2..16
- LOG_DEPTH, 2, log2(DEPTH)

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- CmdWrite  in  1  push request, one per cycle; caller has already qualified it with ~Stall
- CmdFrame  in  32  frame base address for the pushed command
- CmdCode  in  32  GP command code for the pushed command
- CmdFlip  in  1  request a frame flip when this command completes
- Flush  in  1  discard all queued, not-yet-issued commands
- CmdReady  out  1  FIFO not full (combinational from Count)
- Count  out  LOG_DEPTH+1  number of queued commands; excludes the in-flight command
- Busy  out  1  high in ISSUE or WAIT
- DropCount  out  8  pushes lost to a full FIFO, saturating at 255
- gpFrame  out  32  frame of the issued command, registered
- gpCode  out  32  code of the issued command, registered
- gpValid  out  1  single-cycle issue pulse, registered
- gpDone  in  1  GP completion pulse
- FlipReq  out  1  single-cycle flip pulse to the pixel-feeder frame logic, registered

## Operation
- FIFO storage:
  - Entry = {CmdFlip, CmdFrame, CmdCode}, 65 bits.
  - Read and write pointers are LOG_DEPTH bits and wrap modulo DEPTH.
  - Count is the occupancy, range 0..DEPTH.
- Push:
  - Accepted when CmdWrite=1, Count<DEPTH and Flush=0.
  - CmdWrite=1 with Count==DEPTH drops the entry and increments DropCount (saturates at 255). FIFO contents are unchanged.
- Pop: occurs only on the IDLE->ISSUE transition.
- Simultaneous push and pop:
  - Count is unchanged.
  - A push is accepted even when Count==DEPTH, because the pop frees a slot in the same cycle.
- Flush:
  - Sets rd_ptr=wr_ptr and Count=0 on the same edge.
  - A push in the same cycle is discarded and not counted in DropCount.
  - A pop in the same cycle still completes: the command issues and the FIFO ends empty.
  - The in-flight command is not affected.
- FSM states:
  - IDLE:
    - If Count!=0, load gpFrame/gpCode/flip_pending from the FIFO head, pop, and go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE:
    - gpValid=1 for exactly this one cycle.
    - Go to WAIT unconditionally.
  - WAIT:
    - On gpDone=1, pulse FlipReq=1 next cycle if flip_pending=1, then go to IDLE.
    - Otherwise stay in WAIT.
- gpDone handling: gpDone in IDLE or ISSUE is ignored; it does not create a FlipReq.
- Output stability: gpFrame/gpCode hold their last issued values until the next issue, including while in IDLE.
- Reset:
  - State=IDLE; pointers, Count and DropCount = 0.
  - gpFrame=0, gpCode=0, gpValid=0, FlipReq=0, flip_pending=0, Busy=0.
  - Reset mid-command abandons the command; no FlipReq is generated.

## Timing
- All state and all outputs except CmdReady are registered on posedge Clk.
- Push-to-issue latency into an empty, idle scheduler (push sampled at edge E0):
  - Count=1 after E0.
  - IDLE pops at E1; gpValid=1 in the cycle after E1.
  - This gives a two-cycle push-to-gpValid latency.
- Completion:
  - gpDone sampled at edge D gives FlipReq=1 and state IDLE in the cycle after D.
  - A queued next command pops at D+1, so gpValid for it is high two cycles after gpDone.
- Issue rate: at most one command per 3 cycles (IDLE, ISSUE, WAIT each take at least one cycle).
- Busy is high from the cycle after the pop edge through the cycle in which gpDone is sampled.

## Test plan
- Single command, flip requested: reset; push {CmdFlip=1, Frame=0x10400000, Code=0x00000001}.
  - gpValid pulses for 1 cycle, 2 cycles after the push, with gpFrame=0x10400000 and gpCode=1.
  - Assert gpDone 5 cycles later: FlipReq=1 for one cycle, Busy=0, Count=0.
- Fill and overflow, DEPTH=4: hold gpDone=0 and push 6 commands back-to-back.
  - The first issues; 4 are queued, Count=4, CmdReady=0.
  - The 6th push is dropped, DropCount=1.
  - Pulse gpDone 4 times: codes issue in push order 2,3,4,5.
- Simultaneous push and pop at Count==DEPTH: push exactly on the IDLE->ISSUE pop edge.
  - The push is accepted, Count stays 4, DropCount is unchanged.
- Flush during WAIT: 3 commands queued, one in flight; assert Flush together with CmdWrite.
  - Count=0, the flush-cycle push is not stored and DropCount is unchanged.
  - The in-flight command still completes on gpDone and produces FlipReq if its flag is set.
  - No further gpValid pulses follow.
- Spurious done and reset:
  - gpDone in IDLE: no FlipReq, state unchanged.
  - Reset asserted in WAIT with 2 commands queued: all outputs return to 0, a later gpDone gives no FlipReq, Count=0.
- Pointer wrap: 10 push/complete cycles with DEPTH=4.
  - Each gpCode matches its push order; Count returns to 0 and DropCount stays 0.
